rv_dmem: RTL and testbench
==========================

# rv_dmem

Data-memory responder for the 5-stage RV core: the memory end of the `t_core2mem_req` interface driven by the core's memory-access stage. It executes byte-enabled stores and returns load data one cycle after the request. After reset it runs a self-clearing sweep, and it provides a loader port so benches preload data without hierarchical references. It also exposes an out-of-range error flag and saturating access counters.

## Interface
- `DEPTH`, 64: memory depth in 32-bit words. Power of two, ≥4. `AW = $clog2(DEPTH)`.
- `CNT_W`, 16: width of the access counters.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `core2dmem_req`  in  `t_core2mem_req`  core request with fields `address[31:0]`, `wr_data[31:0]`, `wr_en`, `rd_en`, `byte_en[3:0]`.
- `dmem_rd_data`  out  32  registered load data.
- `ld_valid`  in  1  loader write request.
- `ld_addr`  in  AW  loader word index.
- `ld_data`  in  32  loader write data (full word).
- `ld_ready`  out  1  loader write accepted this cycle.
- `init_done`  out  1  high once the clear sweep has finished.
- `oor_err`  out  1  sticky; set by any core access beyond `DEPTH`.
- `rd_cnt`  out  CNT_W  count of accepted core reads, saturating.
- `wr_cnt`  out  CNT_W  count of accepted core writes, saturating.

## Operation
- FSM states: INIT and READY. Reset forces INIT with the sweep pointer `clr_ptr` = 0.
- INIT:
  - Each cycle writes 0 to `mem[clr_ptr]`, then increments `clr_ptr`.
  - When `clr_ptr == DEPTH-1` is written, the next state is READY.
  - INIT lasts exactly DEPTH cycles.
  - Core requests and loader requests are ignored: no write, no count, no error. `ld_ready` stays 0.
- READY: persists until reset.
- Word index: `widx = address[AW+1:2]`. `address[1:0]` is ignored for indexing.
- Out-of-range access: `address[31:AW+2] != 0` with `wr_en` or `rd_en` asserted. The write is dropped, the load returns 0, and `oor_err` is set. `oor_err` clears only on reset.
- Core store (`wr_en`, in range): for each i with `byte_en[i]`, `mem[widx][8i+7:8i] <= wr_data[8i+7:8i]`. Other bytes are unchanged. `byte_en == 0` writes nothing but still counts.
- Core load (`rd_en`): `dmem_rd_data` on the next edge takes `mem[widx]` (0 if out of range). The data is the raw word; sign/zero extension and byte select belong to the core.
- When `rd_en` is low, `dmem_rd_data` holds its previous value.
- Simultaneous read and write of the same word: write-first. The load returns the merged word, meaning new bytes where `byte_en` is set and old bytes elsewhere.
- `wr_en` and `rd_en` both high counts once in each counter.
- Loader:
  - `ld_ready = init_done & ~core2dmem_req.wr_en`. The core store has priority.
  - On `ld_valid & ld_ready`, `mem[ld_addr] <= ld_data`, full word.
  - A loader write is not counted and does not affect `oor_err`.
  - A loader write and a core read to the same word in the same cycle follow the write-first rule.
- Counters: +1 per accepted core access in READY, saturating at all-ones.

## Timing
- Reset values (asynchronous): `dmem_rd_data` = 0, `init_done` = 0, `ld_ready` = 0, `oor_err` = 0, `rd_cnt` = 0, `wr_cnt` = 0, FSM = INIT. Memory contents are undefined until the sweep completes.
- Reset asserted mid-sweep or mid-operation aborts immediately. The sweep restarts from 0 after release.
- `init_done` rises on the edge that completes the write of word DEPTH-1, i.e. DEPTH edges after reset release. Core accesses are honoured from that cycle onward.
- Load latency is 1 cycle: request at edge N produces data valid after edge N+1.
- Store latency is 1 cycle: stored data is visible to a load issued on the following cycle, and to a same-cycle load via write-first.
- `oor_err` and the counters update on the edge that samples the request.
- `ld_ready` is combinational from `init_done` and `wr_en`. A loader write takes effect on the sampling edge.

## Test plan
- Reset/sweep: release `rst`, load 0xDEADBEEF into word 5 via the loader before reset, then reassert and release reset. `init_done` rises after exactly 64 cycles, and a read of 0x14 returns 0x00000000.
- Byte enables:
  - Store 0x11223344 to 0x8 with `byte_en` = 4'b1111.
  - Store 0xAABBCCDD to 0x8 with `byte_en` = 4'b0101.
  - A read of 0x8 returns 0x11BB33DD. `wr_cnt` = 2, `rd_cnt` = 1.
- Write-first: in one cycle, store 0x000000FF to 0x10 with `byte_en` = 4'b0001 and read 0x10 (old value 0x12345678). Next-cycle `dmem_rd_data` = 0x123456FF.
- Out-of-range:
  - Store 0xCAFEF00D to address 0x100 (word 64) → no memory word changes and `oor_err` = 1.
  - Read 0x100 → 0x00000000.
  - `oor_err` stays 1 until reset.
- Loader priority:
  - `ld_valid` with `ld_addr` = 3, `ld_data` = 0x55AA55AA in the same cycle as a core store → `ld_ready` = 0 and no loader write.
  - Retry next cycle → `ld_ready` = 1, and a read of 0xC returns 0x55AA55AA.
- Counter saturation: with `CNT_W` = 4, issue 20 reads → `rd_cnt` holds 4'hF. Requests during INIT are not counted.

Source files
------------

// File: rtl/rv_dmem.sv
// Data-memory responder for the RV core memory stage: byte-enabled stores, registered loads,
// post-reset clear sweep, loader port, out-of-range flag and saturating access counters.
package rv_dmem_pkg;
  typedef struct packed {
    logic [31:0] address;
    logic [31:0] wr_data;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  byte_en;
  } t_core2mem_req;
endpackage

module rv_dmem
  import rv_dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  t_core2mem_req    core2dmem_req,
  output logic [31:0]      dmem_rd_data,
  input  logic             ld_valid,
  input  logic [AW-1:0]    ld_addr,
  input  logic [31:0]      ld_data,
  output logic             ld_ready,
  output logic             init_done,
  output logic             oor_err,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  typedef enum logic {StInit, StReady} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     clr_ptr_q;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_data_q;
  logic              oor_q;
  logic [CNT_W-1:0]  rd_cnt_q, wr_cnt_q;

  logic [AW-1:0]     widx;
  logic              req_oor;
  logic              core_rd, core_wr, wr_hit, ld_fire;
  logic [31:0]       rd_word;
  logic              unused_addr;

  // Byte offset plays no part in word indexing.
  assign unused_addr = ^core2dmem_req.address[1:0];

  assign widx    = core2dmem_req.address[AW+1:2];
  assign req_oor = |core2dmem_req.address[31:AW+2];
  assign core_rd = init_done & core2dmem_req.rd_en;
  assign core_wr = init_done & core2dmem_req.wr_en;
  assign wr_hit  = core_wr & ~req_oor;
  assign ld_fire = ld_valid & ld_ready;

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StInit;
      clr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StInit) clr_ptr_q <= clr_ptr_q + 1'b1;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (state_q == StInit && clr_ptr_q == AW'(DEPTH - 1)) state_d = StReady;
  end

  // FSM: outputs
  always_comb begin
    init_done = (state_q == StReady);
    ld_ready  = init_done & ~core2dmem_req.wr_en;
  end

  // Write-first view of the addressed word as it will look after this edge.
  always_comb begin
    rd_word = mem[widx];
    if (wr_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (core2dmem_req.byte_en[i]) rd_word[8*i +: 8] = core2dmem_req.wr_data[8*i +: 8];
      end
    end
    if (ld_fire && ld_addr == widx) rd_word = ld_data;
    if (req_oor) rd_word = '0;
  end

  always_ff @(posedge clk) begin
    if (!init_done) begin
      mem[clr_ptr_q] <= '0;
    end else begin
      if (wr_hit) begin
        for (int i = 0; i < 4; i++) begin
          if (core2dmem_req.byte_en[i]) mem[widx][8*i +: 8] <= core2dmem_req.wr_data[8*i +: 8];
        end
      end
      if (ld_fire) mem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_q <= '0;
      oor_q     <= 1'b0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      if (core_rd) rd_data_q <= rd_word;
      if ((core_rd || core_wr) && req_oor) oor_q <= 1'b1;
      if (core_rd && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      if (core_wr && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
    end
  end

  assign dmem_rd_data = rd_data_q;
  assign oor_err      = oor_q;
  assign rd_cnt       = rd_cnt_q;
  assign wr_cnt       = wr_cnt_q;

endmodule

// File: tb/tb_rv_dmem.sv
// Randomized + directed bench for rv_dmem with a word-array reference model and a
// scoreboard queue of expected load data drained by an independent monitor.
module tb_rv_dmem;
  import rv_dmem_pkg::*;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  t_core2mem_req    req;
  logic [31:0]      dmem_rd_data;
  logic             ld_valid;
  logic [5:0]       ld_addr;
  logic [31:0]      ld_data;
  logic             ld_ready;
  logic             init_done;
  logic             oor_err;
  logic [CNT_W-1:0] rd_cnt, wr_cnt;

  rv_dmem #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .core2dmem_req(req),
    .dmem_rd_data (dmem_rd_data),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .init_done    (init_done),
    .oor_err      (oor_err),
    .rd_cnt       (rd_cnt),
    .wr_cnt       (wr_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          due;
    int          seq;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];
  int   seq_n = 0;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  bit          m_ready;
  int          m_sweep;
  bit          m_oor;
  int          m_rd_cnt, m_wr_cnt;
  logic [31:0] m_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare registered load data against the entry due on this edge.
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      check($sformatf("rd_data#%0d", e.seq), dmem_rd_data, e.data);
    end
  end

  // Entered at a negedge, returns at the next negedge.
  task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic we,
                       input logic re, input logic [3:0] be, input logic lv,
                       input logic [5:0] la, input logic [31:0] ldd);
    bit       oor;
    int       idx;
    req.address = a;
    req.wr_data = wd;
    req.wr_en   = we;
    req.rd_en   = re;
    req.byte_en = be;
    ld_valid    = lv;
    ld_addr     = la;
    ld_data     = ldd;
    #1;
    check("init_done", 32'(init_done), 32'(m_ready));
    check("ld_ready", 32'(ld_ready), 32'(m_ready && !we));
    check("rd_cnt", 32'(rd_cnt), 32'(m_rd_cnt));
    check("wr_cnt", 32'(wr_cnt), 32'(m_wr_cnt));
    check("oor_err", 32'(oor_err), 32'(m_oor));
    if (!m_ready) begin
      m_sweep++;
      if (m_sweep == DEPTH) begin
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
      end
    end else begin
      oor = (a >= 32'(DEPTH * 4));
      idx = int'(a / 4) % DEPTH;
      if ((we || re) && oor) m_oor = 1'b1;
      if (we) begin
        if (!oor) begin
          for (int b = 0; b < 4; b++) if (be[b]) m_mem[idx][8*b +: 8] = wd[8*b +: 8];
        end
        if (m_wr_cnt < 15) m_wr_cnt++;
      end else if (lv) begin
        m_mem[la] = ldd;
      end
      if (re) begin
        m_rd = oor ? 32'h0 : m_mem[idx];
        if (m_rd_cnt < 15) m_rd_cnt++;
      end
    end
    exp_q.push_back('{due: cyc + 1, seq: seq_n, data: m_rd});
    seq_n++;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 6'h0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a);
    drive(a, 32'h0, 1'b0, 1'b1, 4'h0, 1'b0, 6'h0, 32'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    drive(a, d, 1'b1, 1'b0, be, 1'b0, 6'h0, 32'h0);
  endtask

  task automatic load(input logic [5:0] la, input logic [31:0] d);
    drive(32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 1'b1, la, d);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
    if ($urandom_range(0, 15) == 0) a[31:8] = 24'($urandom_range(1, 32'h00FF_FFFF));
    return a;
  endfunction

  task automatic rand_cycle();
    drive(rand_addr(), $urandom, 1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
          6'($urandom), $urandom);
  endtask

  // Entered at a negedge; releases reset on a negedge.
  task automatic do_reset(input int hold);
    rst = 1'b0;
    req = '0;
    ld_valid = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    #1;
    check("rst_rd_data", dmem_rd_data, 32'h0);
    check("rst_init_done", 32'(init_done), 32'h0);
    check("rst_ld_ready", 32'(ld_ready), 32'h0);
    check("rst_oor_err", 32'(oor_err), 32'h0);
    check("rst_rd_cnt", 32'(rd_cnt), 32'h0);
    check("rst_wr_cnt", 32'(wr_cnt), 32'h0);
    m_ready = 1'b0;
    m_sweep = 0;
    m_oor = 1'b0;
    m_rd_cnt = 0;
    m_wr_cnt = 0;
    m_rd = 32'h0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'hx;
    repeat (hold) @(negedge clk);
    rst = 1'b1;
  endtask

  // Requests thrown at the block during the sweep must all be ignored.
  task automatic sweep();
    repeat (DEPTH) rand_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req = '0;
    ld_valid = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    @(negedge clk);
    do_reset(2);
    sweep();

    // Preloaded word must be wiped by a fresh sweep.
    load(6'd5, 32'hDEADBEEF);
    rd(32'h14);
    idle();
    do_reset(2);
    sweep();
    rd(32'h14);
    idle();

    // Reset mid-sweep restarts from scratch.
    do_reset(1);
    repeat (10) rand_cycle();
    do_reset(3);
    sweep();

    // Byte enables
    wr(32'h8, 32'h11223344, 4'b1111);
    wr(32'h8, 32'hAABBCCDD, 4'b0101);
    rd(32'h8);
    idle();
    check("be_wr_cnt", 32'(wr_cnt), 32'd2);
    check("be_rd_cnt", 32'(rd_cnt), 32'd1);

    // Write-first on a same-cycle store + load
    load(6'd4, 32'h12345678);
    drive(32'h10, 32'h000000FF, 1'b1, 1'b1, 4'b0001, 1'b0, 6'h0, 32'h0);
    idle();

    // Out-of-range: dropped store, zero load, sticky flag, word 0 untouched
    wr(32'h100, 32'hCAFEF00D, 4'hF);
    rd(32'h100);
    rd(32'h0);
    idle();
    check("oor_sticky", 32'(oor_err), 32'h1);

    // Loader blocked by a core store, then retried
    drive(32'h20, 32'h00000777, 1'b1, 1'b0, 4'hF, 1'b1, 6'd3, 32'h55AA55AA);
    load(6'd3, 32'h55AA55AA);
    rd(32'hC);
    idle();

    // Loader write and core read of the same word in one cycle
    drive(32'h24, 32'h0, 1'b0, 1'b1, 4'h0, 1'b1, 6'd9, 32'h0BADCAFE);
    idle();

    // Saturation
    for (int i = 0; i < 20; i++) rd({24'h0, 6'(i), 2'b00});
    idle();
    check("rd_cnt_sat", 32'(rd_cnt), 32'hF);

    repeat (300) rand_cycle();
    idle();
    idle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
